// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds forwarding select / FSM state enums and the load result-select code.
// Also provides a saturating increment used by the performance counters.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        TIMEOUT  = 2'b10
    } hz_state_t;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Operand forwarding select for one ALU source in Execute.
// Ports: rs (source reg), rd_m/reg_write_m, rd_w/reg_write_w -> sel.
// Purely combinational; Memory stage wins over Writeback, x0 never forwards.
module fwd_select
    import hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_w,
    output fwd_sel_t   sel
);

    always_comb begin
        sel = FWD_RF;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush, memory wait/timeout.
// Ports: decode/execute/memory/writeback register ids in; stall/flush/forward selects,
// sticky mem_timeout and saturating stall/flush performance counters out. Outputs combinational.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_d,
    input  logic [4:0]  rs2_d,
    input  logic [4:0]  rs1_e,
    input  logic [4:0]  rs2_e,
    input  logic [4:0]  rd_e,
    input  logic [1:0]  result_src_e,
    input  logic        pc_src_e,
    input  logic        reg_write_m,
    input  logic [4:0]  rd_m,
    input  logic        reg_write_w,
    input  logic [4:0]  rd_w,
    input  logic        mem_req_m,
    input  logic        mem_ready,
    output logic        stall_f,
    output logic        stall_d,
    output logic        stall_e,
    output logic        stall_m,
    output logic        flush_d,
    output logic        flush_e,
    output logic        flush_w,
    output logic [1:0]  forward_a_e,
    output logic [1:0]  forward_b_e,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    // Wait counter value seen in the last permitted stall cycle.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    hz_state_t   state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    fwd_sel_t fwd_a;
    fwd_sel_t fwd_b;

    logic mem_mstall;
    logic load_use;
    logic branch_flush;

    fwd_select u_fwd_a (
        .rs          (rs1_e),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .rd_w        (rd_w),
        .reg_write_w (reg_write_w),
        .sel         (fwd_a)
    );

    fwd_select u_fwd_b (
        .rs          (rs2_e),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .rd_w        (rd_w),
        .reg_write_w (reg_write_w),
        .sel         (fwd_b)
    );

    assign mem_mstall = mem_req_m & ~mem_ready;
    assign load_use   = (result_src_e == RESULT_SRC_LOAD) && (rd_e != 5'd0) &&
                        ((rd_e == rs1_d) || (rd_e == rs2_d));

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        stall_f      = 1'b0;
        stall_d      = 1'b0;
        stall_e      = 1'b0;
        stall_m      = 1'b0;
        flush_d      = 1'b0;
        flush_e      = 1'b0;
        flush_w      = 1'b0;
        branch_flush = 1'b0;

        case (state_q)
            RUN: begin
                // The first stalled cycle already counts toward the timeout.
                if (mem_mstall) begin
                    state_d = MEM_WAIT;
                    wait_d  = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (!mem_mstall) begin
                    state_d = RUN;
                    wait_d  = 8'd0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = TIMEOUT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            TIMEOUT: begin
                state_d = TIMEOUT;
            end
            default: begin
                state_d = RUN;
                wait_d  = 8'd0;
            end
        endcase

        if (!rst) begin
            if ((state_q == TIMEOUT) || mem_mstall) begin
                // Freeze everything up to EX/MEM; a pending branch or load-use
                // stays in its pipeline register and acts once memory answers.
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (pc_src_e) begin
                // The load-use bubble is moot: the dependent instruction is squashed.
                flush_d      = 1'b1;
                flush_e      = 1'b1;
                branch_flush = 1'b1;
            end else if (load_use) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_q      <= 8'd0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (stall_f) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
            if (branch_flush) begin
                flush_cnt_q <= sat_inc(flush_cnt_q);
            end
        end
    end

    // Reset blanks every output immediately, not only after the edge.
    assign forward_a_e  = rst ? 2'b00 : fwd_a;
    assign forward_b_e  = rst ? 2'b00 : fwd_b;
    assign mem_timeout  = ~rst & (state_q == TIMEOUT);
    assign stall_cycles = rst ? 32'd0 : stall_cnt_q;
    assign flush_count  = rst ? 32'd0 : flush_cnt_q;

endmodule
